// File: rtl/mult4_ctrl.sv
// Control FSM for a 4x4 shift-add multiplier: load, clear, four add/shift rounds, done pulse.
// Optional macro MULT_EARLY_DONE_EN: finish as soon as the multiplier register reaches zero.
module mult4_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       q0,
    input  logic       y_zero,
    output logic       ld_x,
    output logic       ld_y,
    output logic       clr_acc,
    output logic       ld_acc,
    output logic       shift,
    output logic       busy,
    output logic       done,
    output logic [1:0] iter
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] iter_reg, iter_next;

`ifdef MULT_EARLY_DONE_EN
    logic early_exit;
    assign early_exit = y_zero;
`else
    logic unused_y_zero;
    assign unused_y_zero = y_zero;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            iter_reg  <= 2'd0;
        end else begin
            state_reg <= state_next;
            iter_reg  <= iter_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        iter_next  = iter_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_LOAD;
            end
            S_LOAD: begin
                iter_next  = 2'd0;
                state_next = S_ADD;
            end
            S_ADD: begin
`ifdef MULT_EARLY_DONE_EN
                state_next = early_exit ? S_DONE : S_SHIFT;
`else
                state_next = S_SHIFT;
`endif
            end
            S_SHIFT: begin
                // iter saturates at 3; only LOAD brings it back to 0
                if (iter_reg == 2'd3) begin
                    state_next = S_DONE;
                end else begin
                    iter_next  = iter_reg + 2'd1;
                    state_next = S_ADD;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ld_x    = 1'b0;
        ld_y    = 1'b0;
        clr_acc = 1'b0;
        ld_acc  = 1'b0;
        shift   = 1'b0;
        done    = 1'b0;
        busy    = (state_reg != S_IDLE);
        case (state_reg)
            S_LOAD: begin
                ld_x    = 1'b1;
                ld_y    = 1'b1;
                clr_acc = 1'b1;
            end
            S_ADD: begin
`ifdef MULT_EARLY_DONE_EN
                ld_acc = q0 & ~early_exit;
`else
                ld_acc = q0;
`endif
            end
            S_SHIFT: shift = 1'b1;
            S_DONE:  done  = 1'b1;
            default: ;
        endcase
    end

    assign iter = iter_reg;

endmodule
